// File: rtl/bp_cfg_boot_sequencer_if.sv
// Config-block command/response port: one uncached read or write in flight,
// command held until accepted, response consumed with yumi.
interface bp_cfg_boot_sequencer_if;
  logic        cmd_v_o;
  logic        cmd_w_o;
  logic [15:0] cmd_addr_o;
  logic [63:0] cmd_data_o;
  logic        cmd_ready_and_i;
  logic        resp_v_i;
  logic [63:0] resp_data_i;
  logic        resp_yumi_o;

  modport master (
    output cmd_v_o, cmd_w_o, cmd_addr_o, cmd_data_o, resp_yumi_o,
    input  cmd_ready_and_i, resp_v_i, resp_data_i
  );

  modport slave (
    input  cmd_v_o, cmd_w_o, cmd_addr_o, cmd_data_o, resp_yumi_o,
    output cmd_ready_and_i, resp_v_i, resp_data_i
  );
endinterface

// File: rtl/bp_cfg_boot_sequencer.sv
// Tile boot sequencer: freeze, program domain/cache modes, load+verify CCE ucode, set CCE mode, unfreeze.
// One command outstanding; 2 cycles per write, 3 per ucode word at zero stall; command held while not ready.
module bp_cfg_boot_sequencer #(
  parameter int          ucode_width_p = 64,
  parameter int          ucode_depth_p = 256,
  parameter logic [15:0] freeze_addr_p = 16'h0001,
  parameter logic [15:0] domain_addr_p = 16'h0002,
  parameter logic [15:0] icache_addr_p = 16'h0003,
  parameter logic [15:0] dcache_addr_p = 16'h0004,
  parameter logic [15:0] cce_addr_p    = 16'h0005,
  parameter logic [15:0] ucode_base_p  = 16'h8000,
  localparam int ucode_addr_width_lp = (ucode_depth_p > 1) ? $clog2(ucode_depth_p) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           start_i,
  input  logic                           skip_ucode_i,
  input  logic [7:0]                     domain_mask_i,
  input  logic [3:0]                     icache_mode_i,
  input  logic [3:0]                     dcache_mode_i,
  input  logic [3:0]                     cce_mode_i,
  bp_cfg_boot_sequencer_if.master        cfg_if,
  output logic                           ucode_r_v_o,
  output logic [ucode_addr_width_lp-1:0] ucode_addr_o,
  input  logic [ucode_width_p-1:0]       ucode_data_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           error_o
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_FREEZE, ST_DOMAIN, ST_ICACHE, ST_DCACHE,
    ST_UC_LOAD, ST_UC_VERIFY, ST_CCE, ST_UNFREEZE, ST_DONE, ST_ERROR
  } step_e;

  typedef enum logic [1:0] {PH_FETCH, PH_SEND, PH_WAIT} phase_e;

  localparam logic [ucode_addr_width_lp-1:0] ucode_last_lp = ucode_addr_width_lp'(ucode_depth_p - 1);

  step_e  step_q, step_n, step_after;
  phase_e phase_q, phase_n;
  logic [ucode_addr_width_lp-1:0] cnt_q, cnt_n;

  logic                     fetch_q;
  logic [ucode_width_p-1:0] word_q;
  logic [ucode_width_p-1:0] cur_word;
  logic [63:0]              word_ext;

  logic       skip_q;
  logic [7:0] domain_q;
  logic [3:0] icache_q, dcache_q, cce_q;

  logic        idle_like, start_take, is_uc;
  logic        send_w;
  logic [15:0] send_addr;
  logic [63:0] send_data;

  assign idle_like  = (step_q == ST_IDLE) || (step_q == ST_DONE) || (step_q == ST_ERROR);
  assign start_take = idle_like && start_i;
  assign is_uc      = (step_q == ST_UC_LOAD) || (step_q == ST_UC_VERIFY);

  // ROM data is only valid the cycle after FETCH; later SEND cycles use the latched copy
  assign cur_word = fetch_q ? ucode_data_i : word_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      step_q   <= ST_IDLE;
      phase_q  <= PH_SEND;
      cnt_q    <= '0;
      fetch_q  <= 1'b0;
      word_q   <= '0;
      skip_q   <= 1'b0;
      domain_q <= '0;
      icache_q <= '0;
      dcache_q <= '0;
      cce_q    <= '0;
    end else begin
      step_q  <= step_n;
      phase_q <= phase_n;
      cnt_q   <= cnt_n;
      fetch_q <= ucode_r_v_o;
      if (fetch_q) begin
        word_q <= ucode_data_i;
      end
      if (start_take) begin
        skip_q   <= skip_ucode_i;
        domain_q <= domain_mask_i;
        icache_q <= icache_mode_i;
        dcache_q <= dcache_mode_i;
        cce_q    <= cce_mode_i;
      end
    end
  end

  always_comb begin
    step_after = ST_DONE;
    case (step_q)
      ST_FREEZE:    step_after = ST_DOMAIN;
      ST_DOMAIN:    step_after = ST_ICACHE;
      ST_ICACHE:    step_after = ST_DCACHE;
      ST_DCACHE:    step_after = skip_q ? ST_CCE : ST_UC_LOAD;
      ST_UC_LOAD:   step_after = ST_UC_VERIFY;
      ST_UC_VERIFY: step_after = ST_CCE;
      ST_CCE:       step_after = ST_UNFREEZE;
      default:      step_after = ST_DONE;
    endcase
  end

  always_comb begin
    word_ext = '0;
    word_ext[ucode_width_p-1:0] = cur_word;
  end

  always_comb begin
    send_w    = 1'b1;
    send_addr = '0;
    send_data = '0;
    case (step_q)
      ST_FREEZE: begin
        send_addr = freeze_addr_p;
        send_data = 64'd1;
      end
      ST_DOMAIN: begin
        send_addr = domain_addr_p;
        send_data = 64'(domain_q);
      end
      ST_ICACHE: begin
        send_addr = icache_addr_p;
        send_data = 64'(icache_q);
      end
      ST_DCACHE: begin
        send_addr = dcache_addr_p;
        send_data = 64'(dcache_q);
      end
      ST_UC_LOAD: begin
        send_addr = ucode_base_p + 16'(cnt_q);
        send_data = word_ext;
      end
      ST_UC_VERIFY: begin
        send_w    = 1'b0;
        send_addr = ucode_base_p + 16'(cnt_q);
      end
      ST_CCE: begin
        send_addr = cce_addr_p;
        send_data = 64'(cce_q);
      end
      ST_UNFREEZE: send_addr = freeze_addr_p;
      default:     send_w    = 1'b0;
    endcase
  end

  always_comb begin
    step_n             = step_q;
    phase_n            = phase_q;
    cnt_n              = cnt_q;
    cfg_if.cmd_v_o     = 1'b0;
    cfg_if.cmd_w_o     = 1'b0;
    cfg_if.cmd_addr_o  = '0;
    cfg_if.cmd_data_o  = '0;
    cfg_if.resp_yumi_o = 1'b0;
    ucode_r_v_o        = 1'b0;
    ucode_addr_o       = '0;
    busy_o             = 1'b0;
    done_o             = 1'b0;
    error_o            = 1'b0;
    case (step_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        done_o  = (step_q == ST_DONE);
        error_o = (step_q == ST_ERROR);
        if (start_i) begin
          step_n  = ST_FREEZE;
          phase_n = PH_SEND;
          cnt_n   = '0;
        end
      end
      default: begin
        busy_o = 1'b1;
        case (phase_q)
          PH_FETCH: begin
            ucode_r_v_o  = 1'b1;
            ucode_addr_o = cnt_q;
            phase_n      = PH_SEND;
          end
          PH_SEND: begin
            cfg_if.cmd_v_o    = 1'b1;
            cfg_if.cmd_w_o    = send_w;
            cfg_if.cmd_addr_o = send_addr;
            cfg_if.cmd_data_o = send_data;
            if (cfg_if.cmd_ready_and_i) begin
              phase_n = PH_WAIT;
            end
          end
          default: begin
            cfg_if.resp_yumi_o = cfg_if.resp_v_i;
            if (cfg_if.resp_v_i) begin
              // A bad readback leaves the tile frozen for the host to inspect
              if (step_q == ST_UC_VERIFY && cfg_if.resp_data_i[ucode_width_p-1:0] != word_q) begin
                step_n = ST_ERROR;
              end else if (is_uc && cnt_q != ucode_last_lp) begin
                cnt_n   = cnt_q + ucode_addr_width_lp'(1);
                phase_n = PH_FETCH;
              end else begin
                cnt_n   = '0;
                step_n  = step_after;
                phase_n = (step_after == ST_UC_LOAD || step_after == ST_UC_VERIFY) ? PH_FETCH : PH_SEND;
              end
            end
          end
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Scoreboarded bench: a config-block memory model answers commands with random stalls,
// a monitor checks every accepted command against the expected boot order.
module tb_bp_cfg_boot_sequencer;

  localparam int DEPTH = 4;

  typedef struct {
    bit          w;
    logic [15:0] addr;
    logic [63:0] data;
  } cmd_t;

  logic        clk_i;
  logic        reset_n_i;
  logic        start_i;
  logic        skip_ucode_i;
  logic [7:0]  domain_mask_i;
  logic [3:0]  icache_mode_i, dcache_mode_i, cce_mode_i;
  logic        ucode_r_v_o;
  logic [1:0]  ucode_addr_o;
  logic [63:0] ucode_data_i;
  logic        busy_o, done_o, error_o;

  bp_cfg_boot_sequencer_if cfg_bus ();

  bp_cfg_boot_sequencer #(.ucode_width_p(64), .ucode_depth_p(DEPTH)) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .start_i       (start_i),
    .skip_ucode_i  (skip_ucode_i),
    .domain_mask_i (domain_mask_i),
    .icache_mode_i (icache_mode_i),
    .dcache_mode_i (dcache_mode_i),
    .cce_mode_i    (cce_mode_i),
    .cfg_if        (cfg_bus.master),
    .ucode_r_v_o   (ucode_r_v_o),
    .ucode_addr_o  (ucode_addr_o),
    .ucode_data_i  (ucode_data_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .error_o       (error_o)
  );

  int          errors = 0;
  int          checks = 0;
  cmd_t        exp_q[$];
  logic [63:0] rom[DEPTH];
  logic [63:0] cfg_mem[logic [15:0]];
  bit          stall_en = 0;
  bit          stray_en = 0;
  int          corrupt_idx = -1;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic any_out();
    return cfg_bus.cmd_v_o | cfg_bus.cmd_w_o | (|cfg_bus.cmd_addr_o) | (|cfg_bus.cmd_data_o) |
           cfg_bus.resp_yumi_o | ucode_r_v_o | (|ucode_addr_o) | busy_o | done_o | error_o;
  endfunction

  // Expected boot order derived from the step list; a verify mismatch truncates after that read
  function automatic void build_exp(input bit skip, input logic [7:0] mask, input logic [3:0] ic,
                                    input logic [3:0] dc, input logic [3:0] cm, input int corrupt);
    exp_q.push_back('{1'b1, 16'h0001, 64'd1});
    exp_q.push_back('{1'b1, 16'h0002, 64'(mask)});
    exp_q.push_back('{1'b1, 16'h0003, 64'(ic)});
    exp_q.push_back('{1'b1, 16'h0004, 64'(dc)});
    if (!skip) begin
      for (int i = 0; i < DEPTH; i++) exp_q.push_back('{1'b1, 16'h8000 + 16'(i), rom[i]});
      for (int i = 0; i < DEPTH; i++) begin
        exp_q.push_back('{1'b0, 16'h8000 + 16'(i), 64'd0});
        if (i == corrupt) return;
      end
    end
    exp_q.push_back('{1'b1, 16'h0005, 64'(cm)});
    exp_q.push_back('{1'b1, 16'h0001, 64'd0});
  endfunction

  // Microcode ROM: one-cycle read latency, garbage when not strobed
  initial begin
    logic       rv;
    logic [1:0] ra;
    ucode_data_i = '0;
    forever begin
      @(negedge clk_i);
      rv = ucode_r_v_o;
      ra = ucode_addr_o;
      @(posedge clk_i);
      #1;
      ucode_data_i = rv ? rom[ra] : {$urandom, $urandom};
    end
  end

  // Config block model: memory, random accept stalls and response delays, optional stray responses
  initial begin
    bit          pend;
    int          dly;
    logic [63:0] rdata;
    logic [15:0] a;
    pend = 0;
    dly = 0;
    rdata = '0;
    cfg_bus.cmd_ready_and_i = 1'b0;
    cfg_bus.resp_v_i = 1'b0;
    cfg_bus.resp_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (!reset_n_i) begin
        pend = 0;
      end else begin
        if (cfg_bus.resp_v_i && cfg_bus.resp_yumi_o) pend = 0;
        if (cfg_bus.cmd_v_o && cfg_bus.cmd_ready_and_i) begin
          pend = 1;
          dly = stall_en ? $urandom_range(0, 5) : 0;
          a = cfg_bus.cmd_addr_o;
          if (cfg_bus.cmd_w_o) begin
            cfg_mem[a] = cfg_bus.cmd_data_o;
            rdata = {$urandom, $urandom};
          end else begin
            rdata = cfg_mem.exists(a) ? cfg_mem[a] : 64'd0;
            if (corrupt_idx >= 0 && a == 16'h8000 + 16'(corrupt_idx))
              rdata = rdata ^ (64'd1 << $urandom_range(0, 63));
          end
        end
      end
      @(posedge clk_i);
      #1;
      cfg_bus.cmd_ready_and_i = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_bus.resp_v_i = 1'b0;
      cfg_bus.resp_data_i = {$urandom, $urandom};
      if (pend) begin
        if (dly == 0) begin
          cfg_bus.resp_v_i = 1'b1;
          cfg_bus.resp_data_i = rdata;
        end else begin
          dly--;
        end
      end else if (stray_en && cfg_bus.cmd_v_o && $urandom_range(0, 2) == 0) begin
        cfg_bus.resp_v_i = 1'b1;
      end
    end
  end

  // Monitor: command order, stall stability, single outstanding, no stray consumption
  initial begin
    int          outstanding;
    bit          stall_prev;
    logic [15:0] s_addr;
    logic [63:0] s_data;
    logic        s_w;
    cmd_t        e;
    outstanding = 0;
    stall_prev = 0;
    s_addr = '0;
    s_data = '0;
    s_w = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!reset_n_i) begin
        outstanding = 0;
        stall_prev = 0;
      end else begin
        if (cfg_bus.resp_v_i && cfg_bus.resp_yumi_o) begin
          check("yumi_with_outstanding", 64'(outstanding != 0), 64'd1);
          if (outstanding != 0) outstanding--;
        end
        if (stall_prev && !cfg_bus.cmd_v_o) check("cmd_dropped_while_stalled", 64'(cfg_bus.cmd_v_o), 64'd1);
        if (cfg_bus.cmd_v_o) begin
          if (stall_prev) begin
            check("stall_addr", cfg_bus.cmd_addr_o, s_addr);
            check("stall_data", cfg_bus.cmd_data_o, s_data);
            check("stall_w", cfg_bus.cmd_w_o, s_w);
          end
          if (cfg_bus.cmd_ready_and_i) begin
            check("one_outstanding", 64'(outstanding), 64'd0);
            outstanding++;
            check("cmd_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("cmd_w", cfg_bus.cmd_w_o, e.w);
              check("cmd_addr", cfg_bus.cmd_addr_o, e.addr);
              if (e.w) check("cmd_data", cfg_bus.cmd_data_o, e.data);
            end
          end
          stall_prev = !cfg_bus.cmd_ready_and_i;
          s_addr = cfg_bus.cmd_addr_o;
          s_data = cfg_bus.cmd_data_o;
          s_w = cfg_bus.cmd_w_o;
        end else begin
          stall_prev = 0;
        end
      end
    end
  end

  task automatic pulse_start(input bit skip, input logic [7:0] mask, input logic [3:0] ic,
                             input logic [3:0] dc, input logic [3:0] cm);
    @(posedge clk_i);
    #1;
    skip_ucode_i = skip;
    domain_mask_i = mask;
    icache_mode_i = ic;
    dcache_mode_i = dc;
    cce_mode_i = cm;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    // The DUT must hold its sampled copies, so the pins are scrambled
    skip_ucode_i = 1'($urandom);
    domain_mask_i = 8'($urandom);
    icache_mode_i = 4'($urandom);
    dcache_mode_i = 4'($urandom);
    cce_mode_i = 4'($urandom);
  endtask

  task automatic run_seq(input bit skip, input logic [7:0] mask, input logic [3:0] ic,
                         input logic [3:0] dc, input logic [3:0] cm, input bit stall,
                         input int corrupt, input int busy_k, input bit stray, input int exp_lat);
    int k;
    stall_en = stall;
    stray_en = stray;
    corrupt_idx = corrupt;
    for (int i = 0; i < DEPTH; i++) rom[i] = {$urandom, $urandom};
    build_exp(skip, mask, ic, dc, cm, corrupt);
    pulse_start(skip, mask, ic, dc, cm);
    k = 0;
    forever begin
      @(negedge clk_i);
      if (k == 0) begin
        check("cmd_v_after_start", 64'(cfg_bus.cmd_v_o), 64'd1);
        check("status_cleared", {62'd0, done_o, error_o}, 64'd0);
      end
      if (done_o || error_o || k > 3000) break;
      @(posedge clk_i);
      #1;
      k++;
      start_i = (k == busy_k);
    end
    start_i = 1'b0;
    check("finished_in_budget", 64'(k <= 3000), 64'd1);
    if (exp_lat >= 0) check("latency", 64'(k), 64'(exp_lat));
    check("busy_at_end", 64'(busy_o), 64'd0);
    check("all_cmds_seen", 64'(exp_q.size()), 64'd0);
    if (corrupt >= 0) begin
      check("error_flag", {62'd0, error_o, done_o}, 64'd2);
      repeat (20) @(negedge clk_i);
      check("error_held", 64'(error_o), 64'd1);
      check("tile_left_frozen", cfg_mem[16'h0001], 64'd1);
    end else begin
      check("done_flag", {62'd0, done_o, error_o}, 64'd2);
      repeat (3) @(negedge clk_i);
      check("done_held", 64'(done_o), 64'd1);
      check("tile_unfrozen", cfg_mem[16'h0001], 64'd0);
    end
    exp_q.delete();
  endtask

  task automatic reset_mid_load();
    bit found;
    stall_en = 0;
    stray_en = 0;
    corrupt_idx = -1;
    for (int i = 0; i < DEPTH; i++) rom[i] = {$urandom, $urandom};
    build_exp(1'b0, 8'h3C, 4'h7, 4'h9, 4'hB, -1);
    pulse_start(1'b0, 8'h3C, 4'h7, 4'h9, 4'hB);
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge clk_i);
      #1;
      found = cfg_bus.cmd_v_o && cfg_bus.cmd_w_o && cfg_bus.cmd_addr_o == 16'h8001;
    end
    check("reached_word1_send", 64'(found), 64'd1);
    reset_n_i = 1'b0;
    #1;
    check("async_reset_outputs", 64'(any_out()), 64'd0);
    exp_q.delete();
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    #1;
    check("post_reset_idle", 64'(any_out()), 64'd0);
    run_seq(1'b0, 8'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b0, -1, -1, 1'b0,
            12 + 6 * DEPTH);
  endtask

  initial begin
    reset_n_i = 1'b0;
    start_i = 1'b0;
    skip_ucode_i = 1'b0;
    domain_mask_i = '0;
    icache_mode_i = '0;
    dcache_mode_i = '0;
    cce_mode_i = '0;
    #2;
    check("reset_outputs", 64'(any_out()), 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    @(negedge clk_i);
    check("idle_outputs", 64'(any_out()), 64'd0);

    // Zero stall: six writes at 2 cycles plus 2*DEPTH words at 3 cycles
    run_seq(1'b0, 8'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b0, -1, -1, 1'b0,
            12 + 6 * DEPTH);
    // Microcode skipped: six register writes at two cycles each
    run_seq(1'b1, 8'h5A, 4'h2, 4'($urandom), 4'h1, 1'b0, -1, -1, 1'b0, 12);
    for (int r = 0; r < 3; r++)
      run_seq(1'(r == 2), 8'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b1, -1, -1,
              1'b0, -1);
    // Word 2 readback corrupted: error after its verify response
    run_seq(1'b0, 8'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b0, 2, -1, 1'b0,
            8 + 3 * DEPTH + 3 * 3);
    // Restart from ERROR with a start pulse while busy and stray responses in SEND
    run_seq(1'b0, 8'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b0, -1, 5, 1'b1,
            12 + 6 * DEPTH);
    run_seq(1'b0, 8'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b1, -1, 7, 1'b1, -1);
    reset_mid_load();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
